// File: rtl/axis_max_arbiter.sv
// Packet-level round-robin arbiter that shares one AXI-Stream max-finder between NUM_SRC sources.
// The grant is locked for a whole packet; beats pass through combinationally, tagged with the source ID.
module axis_max_arbiter #(
  parameter int STREAM_WIDTH = 32,
  parameter int NUM_SRC      = 4,
  parameter int LEN_WIDTH    = 16,
  localparam int ID_WIDTH    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                            ACLK,
  input  logic                            ARESET_n,
  input  logic [NUM_SRC*STREAM_WIDTH-1:0] S_TDATA,
  input  logic [NUM_SRC-1:0]              S_TVALID,
  input  logic [NUM_SRC-1:0]              S_TLAST,
  output logic [NUM_SRC-1:0]              S_TREADY,
  output logic [STREAM_WIDTH-1:0]         M_TDATA,
  output logic                            M_TVALID,
  output logic                            M_TLAST,
  output logic [ID_WIDTH-1:0]             M_TID,
  input  logic                            M_TREADY,
  output logic                            pkt_done,
  output logic [ID_WIDTH-1:0]             pkt_id,
  output logic [LEN_WIDTH-1:0]            pkt_len
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                  state_reg, state_next;
  logic [ID_WIDTH-1:0]     grant_reg, grant_next;
  logic [ID_WIDTH-1:0]     rr_ptr_reg, rr_ptr_next;
  logic [LEN_WIDTH-1:0]    beat_cnt_reg, beat_cnt_next, beat_cnt_inc;
  logic                    pkt_done_reg, pkt_done_next;
  logic [ID_WIDTH-1:0]     pkt_id_reg, pkt_id_next;
  logic [LEN_WIDTH-1:0]    pkt_len_reg, pkt_len_next;

  logic [STREAM_WIDTH-1:0] s_data_arr [NUM_SRC];
  logic                    locked;
  logic                    beat_accept;
  logic                    scan_hit;
  logic [ID_WIDTH-1:0]     scan_idx;
  int                      scan_pos;

  assign locked = (state_reg == LOCKED);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign s_data_arr[gi] = S_TDATA[gi*STREAM_WIDTH +: STREAM_WIDTH];
      assign S_TREADY[gi]   = locked && (grant_reg == ID_WIDTH'(gi)) && M_TREADY;
    end
  endgenerate

  // Data mux follows grant even in IDLE; it is qualified by M_TVALID downstream.
  assign M_TDATA     = s_data_arr[grant_reg];
  assign M_TVALID    = locked & S_TVALID[grant_reg];
  assign M_TLAST     = locked & S_TLAST[grant_reg];
  assign M_TID       = grant_reg;
  assign beat_accept = M_TVALID & M_TREADY;

  assign pkt_done = pkt_done_reg;
  assign pkt_id   = pkt_id_reg;
  assign pkt_len  = pkt_len_reg;

  assign beat_cnt_inc = (&beat_cnt_reg) ? beat_cnt_reg : beat_cnt_reg + LEN_WIDTH'(1);

  // Scan downwards so the candidate closest to rr_ptr is written last and wins.
  always_comb begin
    scan_hit = 1'b0;
    scan_idx = '0;
    scan_pos = 0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      scan_pos = (int'(rr_ptr_reg) + k) % NUM_SRC;
      if (S_TVALID[ID_WIDTH'(scan_pos)]) begin
        scan_hit = 1'b1;
        scan_idx = ID_WIDTH'(scan_pos);
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    rr_ptr_next   = rr_ptr_reg;
    beat_cnt_next = beat_cnt_reg;
    pkt_done_next = 1'b0;
    pkt_id_next   = pkt_id_reg;
    pkt_len_next  = pkt_len_reg;
    case (state_reg)
      IDLE: begin
        if (scan_hit) begin
          state_next    = LOCKED;
          grant_next    = scan_idx;
          beat_cnt_next = '0;
        end
      end
      LOCKED: begin
        if (beat_accept) begin
          beat_cnt_next = beat_cnt_inc;
          if (M_TLAST) begin
            state_next    = IDLE;
            rr_ptr_next   = (grant_reg == ID_WIDTH'(NUM_SRC - 1)) ? '0 : grant_reg + ID_WIDTH'(1);
            pkt_done_next = 1'b1;
            pkt_id_next   = grant_reg;
            pkt_len_next  = beat_cnt_inc;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESET_n) begin
    if (!ARESET_n) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      rr_ptr_reg   <= '0;
      beat_cnt_reg <= '0;
      pkt_done_reg <= 1'b0;
      pkt_id_reg   <= '0;
      pkt_len_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      rr_ptr_reg   <= rr_ptr_next;
      beat_cnt_reg <= beat_cnt_next;
      pkt_done_reg <= pkt_done_next;
      pkt_id_reg   <= pkt_id_next;
      pkt_len_reg  <= pkt_len_next;
    end
  end

endmodule

// File: tb/tb_axis_max_arbiter.sv
// Directed bench for axis_max_arbiter: 4-source default, 3-source wrap, and 1-source/4-bit-length instances.
module tb_axis_max_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // default instance: NUM_SRC=4, LEN_WIDTH=16
  logic [127:0] s_tdata;
  logic [3:0]   s_tvalid, s_tlast, s_tready;
  logic [31:0]  m_tdata;
  logic         m_tvalid, m_tlast, m_tready, pkt_done;
  logic [1:0]   m_tid, pkt_id;
  logic [15:0]  pkt_len;

  // NUM_SRC=3 instance
  logic [95:0]  t3_s_tdata;
  logic [2:0]   t3_s_tvalid, t3_s_tlast, t3_s_tready;
  logic [31:0]  t3_m_tdata;
  logic         t3_m_tvalid, t3_m_tlast, t3_m_tready, t3_pkt_done;
  logic [1:0]   t3_m_tid, t3_pkt_id;
  logic [15:0]  t3_pkt_len;

  // NUM_SRC=1, LEN_WIDTH=4 instance
  logic [31:0]  l_s_tdata;
  logic [0:0]   l_s_tvalid, l_s_tlast, l_s_tready;
  logic [31:0]  l_m_tdata;
  logic         l_m_tvalid, l_m_tlast, l_m_tready, l_pkt_done;
  logic [0:0]   l_m_tid, l_pkt_id;
  logic [3:0]   l_pkt_len;

  axis_max_arbiter #(.STREAM_WIDTH(32), .NUM_SRC(4), .LEN_WIDTH(16)) dut (
    .ACLK(clk), .ARESET_n(rst_n),
    .S_TDATA(s_tdata), .S_TVALID(s_tvalid), .S_TLAST(s_tlast), .S_TREADY(s_tready),
    .M_TDATA(m_tdata), .M_TVALID(m_tvalid), .M_TLAST(m_tlast), .M_TID(m_tid), .M_TREADY(m_tready),
    .pkt_done(pkt_done), .pkt_id(pkt_id), .pkt_len(pkt_len)
  );

  axis_max_arbiter #(.STREAM_WIDTH(32), .NUM_SRC(3), .LEN_WIDTH(16)) dut3 (
    .ACLK(clk), .ARESET_n(rst_n),
    .S_TDATA(t3_s_tdata), .S_TVALID(t3_s_tvalid), .S_TLAST(t3_s_tlast), .S_TREADY(t3_s_tready),
    .M_TDATA(t3_m_tdata), .M_TVALID(t3_m_tvalid), .M_TLAST(t3_m_tlast), .M_TID(t3_m_tid),
    .M_TREADY(t3_m_tready),
    .pkt_done(t3_pkt_done), .pkt_id(t3_pkt_id), .pkt_len(t3_pkt_len)
  );

  axis_max_arbiter #(.STREAM_WIDTH(32), .NUM_SRC(1), .LEN_WIDTH(4)) dutl (
    .ACLK(clk), .ARESET_n(rst_n),
    .S_TDATA(l_s_tdata), .S_TVALID(l_s_tvalid), .S_TLAST(l_s_tlast), .S_TREADY(l_s_tready),
    .M_TDATA(l_m_tdata), .M_TVALID(l_m_tvalid), .M_TLAST(l_m_tlast), .M_TID(l_m_tid),
    .M_TREADY(l_m_tready),
    .pkt_done(l_pkt_done), .pkt_id(l_pkt_id), .pkt_len(l_pkt_len)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drv(input int s, input logic v, input logic [31:0] d, input logic l);
    s_tvalid[s]         = v;
    s_tdata[s*32 +: 32] = d;
    s_tlast[s]          = l;
  endtask

  task automatic drv3(input int s, input logic v, input logic [31:0] d, input logic l);
    t3_s_tvalid[s]         = v;
    t3_s_tdata[s*32 +: 32] = d;
    t3_s_tlast[s]          = l;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] vals5 [5];
  logic [31:0] vals100 [100];
  int          g;
  int          idx;
  int          cyc;

  initial begin
    rst_n = 1'b0;
    s_tdata = '0; s_tvalid = '0; s_tlast = '0; m_tready = 1'b1;
    t3_s_tdata = '0; t3_s_tvalid = '0; t3_s_tlast = '0; t3_m_tready = 1'b1;
    l_s_tdata = '0; l_s_tvalid = '0; l_s_tlast = '0; l_m_tready = 1'b1;
    vals5[0] = 32'd10; vals5[1] = 32'd700; vals5[2] = 32'd3; vals5[3] = 32'd65000; vals5[4] = 32'd42;
    s_tdata[31:0] = 32'hCAFE0001;
    s_tvalid      = 4'hF;

    // ---- reset state, including across a clock edge with sources valid
    #3;
    chk("rst_s_tready", 64'(s_tready), 64'(4'b0000));
    chk("rst_m_tvalid", 64'(m_tvalid), 64'(1'b0));
    chk("rst_m_tlast", 64'(m_tlast), 64'(1'b0));
    chk("rst_m_tid", 64'(m_tid), 64'(2'd0));
    chk("rst_m_tdata", 64'(m_tdata), 64'(32'hCAFE0001));
    chk("rst_pkt_done", 64'(pkt_done), 64'(1'b0));
    chk("rst_pkt_id", 64'(pkt_id), 64'(2'd0));
    chk("rst_pkt_len", 64'(pkt_len), 64'(16'd0));
    tick();
    chk("rst_edge_m_tvalid", 64'(m_tvalid), 64'(1'b0));
    chk("rst_edge_s_tready", 64'(s_tready), 64'(4'b0000));
    rst_n = 1'b1;

    // ---- all four sources valid, 2-beat packets: grants 0,1,2,3,0,1
    for (int s = 0; s < 4; s++) drv(s, 1'b1, 32'h0, 1'b0);
    settle();
    chk("rr_idle_m_tvalid", 64'(m_tvalid), 64'(1'b0));
    tick();
    for (int p = 0; p < 6; p++) begin
      g = p % 4;
      for (int b = 0; b < 2; b++) begin
        drv(g, 1'b1, 32'hA0000000 | (p << 4) | b, (b == 1));
        settle();
        chk("rr_m_tvalid", 64'(m_tvalid), 64'(1'b1));
        chk("rr_m_tid", 64'(m_tid), 64'(g));
        chk("rr_m_tdata", 64'(m_tdata), 64'(32'hA0000000 | (p << 4) | b));
        chk("rr_m_tlast", 64'(m_tlast), 64'(b == 1));
        chk("rr_s_tready", 64'(s_tready), 64'(1 << g));
        if (b == 0) chk("rr_pkt_done_low", 64'(pkt_done), 64'(1'b0));
        tick();
      end
      drv(g, 1'b1, 32'h0, 1'b0);
      if (p == 5) s_tvalid = 4'b0000;
      settle();
      chk("rr_bubble_m_tvalid", 64'(m_tvalid), 64'(1'b0));
      chk("rr_bubble_s_tready", 64'(s_tready), 64'(4'b0000));
      chk("rr_pkt_done", 64'(pkt_done), 64'(1'b1));
      chk("rr_pkt_id", 64'(pkt_id), 64'(g));
      chk("rr_pkt_len", 64'(pkt_len), 64'(16'd2));
      tick();
    end

    // ---- single source 0, five beats (rr_ptr=2 wraps through 3 to 0)
    drv(0, 1'b1, vals5[0], 1'b0);
    settle();
    chk("one_idle_m_tvalid", 64'(m_tvalid), 64'(1'b0));
    tick();
    for (int b = 0; b < 5; b++) begin
      drv(0, 1'b1, vals5[b], (b == 4));
      settle();
      chk("one_m_tvalid", 64'(m_tvalid), 64'(1'b1));
      chk("one_m_tid", 64'(m_tid), 64'(2'd0));
      chk("one_m_tdata", 64'(m_tdata), 64'(vals5[b]));
      chk("one_m_tlast", 64'(m_tlast), 64'(b == 4));
      chk("one_s_tready", 64'(s_tready), 64'(4'b0001));
      tick();
    end
    drv(0, 1'b0, 32'h0, 1'b0);
    settle();
    chk("one_pkt_done", 64'(pkt_done), 64'(1'b1));
    chk("one_pkt_id", 64'(pkt_id), 64'(2'd0));
    chk("one_pkt_len", 64'(pkt_len), 64'(16'd5));
    tick();
    chk("one_pkt_done_pulse", 64'(pkt_done), 64'(1'b0));
    chk("one_pkt_len_hold", 64'(pkt_len), 64'(16'd5));

    // ---- granted source 1 stalls 4 cycles while source 3 waits
    drv(1, 1'b1, 32'h111, 1'b0);
    drv(3, 1'b1, 32'h333, 1'b1);
    tick();
    chk("stall_m_tid", 64'(m_tid), 64'(2'd1));
    chk("stall_m_tdata0", 64'(m_tdata), 64'(32'h111));
    chk("stall_s_tready0", 64'(s_tready), 64'(4'b0010));
    tick();
    for (int c = 0; c < 4; c++) begin
      drv(1, 1'b0, 32'hDEAD, 1'b0);
      settle();
      chk("stall_m_tvalid", 64'(m_tvalid), 64'(1'b0));
      chk("stall_grant_held", 64'(m_tid), 64'(2'd1));
      chk("stall_s_tready3", 64'(s_tready[3]), 64'(1'b0));
      chk("stall_s_tready", 64'(s_tready), 64'(4'b0010));
      tick();
    end
    drv(1, 1'b1, 32'h112, 1'b1);
    settle();
    chk("stall_resume_m_tvalid", 64'(m_tvalid), 64'(1'b1));
    chk("stall_resume_m_tdata", 64'(m_tdata), 64'(32'h112));
    chk("stall_resume_m_tlast", 64'(m_tlast), 64'(1'b1));
    tick();
    drv(1, 1'b0, 32'h0, 1'b0);
    settle();
    chk("stall_pkt_done", 64'(pkt_done), 64'(1'b1));
    chk("stall_pkt_id", 64'(pkt_id), 64'(2'd1));
    chk("stall_pkt_len", 64'(pkt_len), 64'(16'd2));
    tick();
    chk("next_m_tid", 64'(m_tid), 64'(2'd3));
    chk("next_m_tdata", 64'(m_tdata), 64'(32'h333));
    chk("next_s_tready", 64'(s_tready), 64'(4'b1000));
    tick();
    drv(3, 1'b0, 32'h0, 1'b0);
    settle();
    chk("next_pkt_id", 64'(pkt_id), 64'(2'd3));
    chk("next_pkt_len", 64'(pkt_len), 64'(16'd1));
    tick();

    // ---- 100-beat packet from source 0 with random M_TREADY
    for (int i = 0; i < 100; i++) vals100[i] = $urandom_range(0, 65000);
    idx = 0;
    cyc = 0;
    drv(0, 1'b1, vals100[0], 1'b0);
    tick();
    while (idx < 100 && cyc < 2000) begin
      drv(0, 1'b1, vals100[idx], (idx == 99));
      m_tready = 1'($urandom_range(0, 1));
      settle();
      chk("rand_m_tvalid", 64'(m_tvalid), 64'(1'b1));
      chk("rand_m_tdata", 64'(m_tdata), 64'(vals100[idx]));
      chk("rand_m_tlast", 64'(m_tlast), 64'(idx == 99));
      chk("rand_s_tready", 64'(s_tready), 64'({3'b000, m_tready}));
      if (m_tready) idx++;
      cyc++;
      tick();
    end
    chk("rand_beats_done", 64'(idx), 64'(100));
    m_tready = 1'b1;
    drv(0, 1'b0, 32'h0, 1'b0);
    settle();
    chk("rand_pkt_done", 64'(pkt_done), 64'(1'b1));
    chk("rand_pkt_id", 64'(pkt_id), 64'(2'd0));
    chk("rand_pkt_len", 64'(pkt_len), 64'(16'd100));
    tick();

    // ---- NUM_SRC=1, LEN_WIDTH=4: 20 beats saturate the count at 15
    l_s_tvalid = 1'b1;
    l_s_tdata  = 32'h500;
    l_s_tlast  = 1'b0;
    settle();
    chk("sat_idle_m_tvalid", 64'(l_m_tvalid), 64'(1'b0));
    tick();
    for (int b = 0; b < 20; b++) begin
      l_s_tdata = 32'h500 + b;
      l_s_tlast = (b == 19);
      settle();
      chk("sat_m_tvalid", 64'(l_m_tvalid), 64'(1'b1));
      chk("sat_m_tdata", 64'(l_m_tdata), 64'(32'h500 + b));
      chk("sat_m_tlast", 64'(l_m_tlast), 64'(b == 19));
      chk("sat_s_tready", 64'(l_s_tready), 64'(1'b1));
      tick();
    end
    l_s_tvalid = 1'b0;
    settle();
    chk("sat_pkt_done", 64'(l_pkt_done), 64'(1'b1));
    chk("sat_pkt_id", 64'(l_pkt_id), 64'(1'b0));
    chk("sat_pkt_len", 64'(l_pkt_len), 64'(4'd15));
    tick();

    // ---- NUM_SRC=3: move rr_ptr to 2, then sources 1 and 2 -> 2 then wrap to 1
    drv3(1, 1'b1, 32'h31, 1'b1);
    tick();
    chk("w3_first_m_tid", 64'(t3_m_tid), 64'(2'd1));
    tick();
    drv3(1, 1'b1, 32'h41, 1'b1);
    drv3(2, 1'b1, 32'h42, 1'b1);
    settle();
    chk("w3_first_pkt_id", 64'(t3_pkt_id), 64'(2'd1));
    tick();
    chk("w3_grant2_m_tid", 64'(t3_m_tid), 64'(2'd2));
    chk("w3_grant2_m_tdata", 64'(t3_m_tdata), 64'(32'h42));
    chk("w3_grant2_s_tready", 64'(t3_s_tready), 64'(3'b100));
    tick();
    drv3(2, 1'b0, 32'h0, 1'b0);
    settle();
    chk("w3_bubble_m_tvalid", 64'(t3_m_tvalid), 64'(1'b0));
    chk("w3_pkt_id2", 64'(t3_pkt_id), 64'(2'd2));
    tick();
    chk("w3_wrap_m_tid", 64'(t3_m_tid), 64'(2'd1));
    chk("w3_wrap_m_tdata", 64'(t3_m_tdata), 64'(32'h41));
    chk("w3_wrap_s_tready", 64'(t3_s_tready), 64'(3'b010));
    tick();
    drv3(1, 1'b0, 32'h0, 1'b0);
    settle();
    chk("w3_pkt_done", 64'(t3_pkt_done), 64'(1'b1));
    tick();

    // ---- reset mid-packet: source 2 granted (rr_ptr=1), reset on beat 3 of 6
    drv(0, 1'b1, 32'h50, 1'b1);
    drv(2, 1'b1, 32'h60, 1'b0);
    tick();
    for (int b = 0; b < 3; b++) begin
      drv(2, 1'b1, 32'h60 + b, 1'b0);
      settle();
      chk("mid_m_tid", 64'(m_tid), 64'(2'd2));
      chk("mid_m_tdata", 64'(m_tdata), 64'(32'h60 + b));
      tick();
    end
    drv(2, 1'b1, 32'h63, 1'b0);
    settle();
    chk("mid_pre_rst_m_tvalid", 64'(m_tvalid), 64'(1'b1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_s_tready", 64'(s_tready), 64'(4'b0000));
    chk("mid_rst_m_tvalid", 64'(m_tvalid), 64'(1'b0));
    chk("mid_rst_m_tlast", 64'(m_tlast), 64'(1'b0));
    chk("mid_rst_m_tid", 64'(m_tid), 64'(2'd0));
    chk("mid_rst_m_tdata", 64'(m_tdata), 64'(32'h50));
    chk("mid_rst_pkt_done", 64'(pkt_done), 64'(1'b0));
    tick();
    chk("mid_rst_edge_pkt_done", 64'(pkt_done), 64'(1'b0));
    rst_n = 1'b1;
    settle();
    chk("mid_rel_m_tvalid", 64'(m_tvalid), 64'(1'b0));
    tick();
    chk("mid_regrant_m_tid", 64'(m_tid), 64'(2'd0));
    chk("mid_regrant_m_tvalid", 64'(m_tvalid), 64'(1'b1));
    chk("mid_regrant_m_tdata", 64'(m_tdata), 64'(32'h50));
    chk("mid_regrant_s_tready", 64'(s_tready), 64'(4'b0001));
    tick();
    drv(0, 1'b0, 32'h0, 1'b0);
    drv(2, 1'b0, 32'h0, 1'b0);
    settle();
    chk("mid_after_pkt_done", 64'(pkt_done), 64'(1'b1));
    chk("mid_after_pkt_id", 64'(pkt_id), 64'(2'd0));
    chk("mid_after_pkt_len", 64'(pkt_len), 64'(16'd1));
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axis_max_arbiter.md
# axis_max_arbiter

Packet-level round-robin arbiter that shares one AXI-Stream max-finder datapath between NUM_SRC upstream sources. It grants one source at a time, locks the grant for a whole packet (until the TLAST beat is accepted), and passes beats through unmodified. It tags each beat with the granted source ID and reports per-packet completion so the max result can be attributed to its source. It sits between the sample producers and the max-finder's AXI-Stream slave port.

## Interface
- STREAM_WIDTH, 32, TDATA width per stream
- NUM_SRC, 4, number of upstream sources (1..16)
- LEN_WIDTH, 16, width of packet beat counter
- ID_WIDTH, derived = max(1, $clog2(NUM_SRC)), not overridden

- ACLK  in  1  clock, all logic rising-edge
- ARESET_n  in  1  asynchronous, active-low reset
- S_TDATA  in  NUM_SRC*STREAM_WIDTH  source data, source i at [i*STREAM_WIDTH +: STREAM_WIDTH]
- S_TVALID  in  NUM_SRC  per-source valid
- S_TLAST  in  NUM_SRC  per-source last
- S_TREADY  out  NUM_SRC  per-source ready
- M_TDATA  out  STREAM_WIDTH  to max-finder
- M_TVALID  out  1  to max-finder
- M_TLAST  out  1  to max-finder
- M_TID  out  ID_WIDTH  granted source index
- M_TREADY  in  1  from max-finder
- pkt_done  out  1  one-cycle pulse, packet finished
- pkt_id  out  ID_WIDTH  source of finished packet
- pkt_len  out  LEN_WIDTH  beats in finished packet, saturating

## Operation
- States: IDLE, LOCKED. Registers: state, grant (ID_WIDTH), rr_ptr (ID_WIDTH), beat_cnt (LEN_WIDTH), pkt_done/pkt_id/pkt_len.
- IDLE: S_TREADY all 0, M_TVALID 0. Scan i = rr_ptr, rr_ptr+1, ... wrapping modulo NUM_SRC (not 2^ID_WIDTH); first i with S_TVALID[i]=1 loads grant=i, beat_cnt=0, state->LOCKED. None valid: stay IDLE.
- LOCKED (combinational pass-through): M_TDATA/M_TVALID/M_TLAST = S_*[grant]; S_TREADY[grant]=M_TREADY, all others 0; M_TID=grant.
- Beat accepted = M_TVALID & M_TREADY. Each accepted beat increments beat_cnt, saturating at 2^LEN_WIDTH-1.
- Accepted beat with M_TLAST=1: state->IDLE; rr_ptr = (grant+1) mod NUM_SRC; next cycle pkt_done=1, pkt_id=grant, pkt_len=final count including the last beat (saturated).
- Granted source dropping TVALID mid-packet: grant held, M_TVALID=0, no re-arbitration; other sources stall indefinitely (no timeout).
- Data, TLAST passed bit-exact; arbiter never inserts, drops or reorders beats.
- NUM_SRC=1: degenerates to pass-through with one IDLE bubble per packet; rr_ptr stays 0.

## Timing
- Reset (ARESET_n=0, asynchronous): state=IDLE, grant=0, rr_ptr=0, beat_cnt=0, pkt_done=0, pkt_id=0, pkt_len=0. Hence S_TREADY=0, M_TVALID=0, M_TLAST=0, M_TID=0, M_TDATA=S_TDATA[0 slice] (don't-care while invalid). Release synchronous to ACLK is the integrator's responsibility.
- Arbitration latency: source valid sampled in IDLE at edge N -> LOCKED from edge N+1; first beat may transfer in cycle N+1.
- Throughput: packet of L beats with M_TREADY=1 occupies L+1 cycles (one IDLE bubble per packet).
- pkt_done asserts the cycle after the TLAST beat is accepted, for exactly one cycle; pkt_id/pkt_len hold until next pkt_done.
- Zero-latency combinational paths S->M and M_TREADY->S_TREADY in LOCKED.
- Reset mid-packet: grant dropped immediately, partial packet truncated, no pkt_done; downstream must be reset together.
- TLAST beat accepted and new source valid in same cycle: no same-cycle regrant; next packet starts after the IDLE cycle.

## Test plan
- Single source 0, packet of 5 beats (values 10,700,3,65000,42), M_TREADY=1 -> 5 beats out in order with M_TID=0, M_TLAST on beat 5, pkt_done one cycle later with pkt_id=0, pkt_len=5.
- All 4 sources continuously valid with 2-beat packets -> grant order 0,1,2,3,0,1; each packet 3 cycles; no beat interleaving between sources.
- NUM_SRC=3, sources 1 and 2 valid, rr_ptr=2 -> source 2 granted first, then wraps to 1 (not index 3).
- Granted source deasserts TVALID for 4 cycles mid-packet while source 3 valid -> M_TVALID=0 for 4 cycles, S_TREADY[3]=0 throughout, grant unchanged, packet completes.
- M_TREADY toggled randomly during a 100-beat $urandom_range(0,65000) packet -> output beat sequence equals input, pkt_len=100; LEN_WIDTH=4 with 20-beat packet -> pkt_len=15.
- ARESET_n pulsed low mid-packet (beat 3 of 6) -> all outputs at reset values within the reset cycle, no pkt_done; after release, source 0 re-arbitrated from rr_ptr=0.
